// File: rtl/pe_nic_pkg.sv
// pe_nic_pkg -- shared constants for the processor-side network interface.
//
// Contents:
//   ADDR_OUT_BUF  : register select for the output-channel buffer (write-only)
//   ADDR_OUT_STAT : register select for the output status word
//   ADDR_IN_BUF   : register select for the input-channel buffer (read-only)
//   ADDR_IN_STAT  : register select for the input status word
//   PKT_VC_BIT    : packet header bit carrying the virtual-channel polarity
package pe_nic_pkg;

  localparam logic [1:0] ADDR_OUT_BUF  = 2'd0;
  localparam logic [1:0] ADDR_OUT_STAT = 2'd1;
  localparam logic [1:0] ADDR_IN_BUF   = 2'd2;
  localparam logic [1:0] ADDR_IN_STAT  = 2'd3;

  localparam int PKT_VC_BIT = 63;

endpackage

// File: rtl/nic_chan_buf.sv
// nic_chan_buf -- one-entry packet buffer with full/empty flags.
//
// Ports:
//   i_clk   : clock, rising-edge
//   i_rst_n : asynchronous active-low reset (clears data, full=0, empty=1)
//   i_load  : offer i_data; accepted only when the buffer is empty
//   i_data  : packet to store
//   i_clear : release the stored packet; honoured only when full
//   o_data  : stored packet (kept after a clear, so a late read sees stale data)
//   o_full  : buffer holds a packet
//   o_empty : registered complement of o_full, usable as a ready signal
//
// Handshake: a load is taken at an edge only if the buffer was empty before
// that edge; a clear at the same edge as a load on a full buffer wins and the
// load is dropped.
module nic_chan_buf #(
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clear,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_data;
  logic              r_full;
  logic              r_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else if (r_full && i_clear) begin
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else if (!r_full && i_load) begin
      r_data  <= i_data;
      r_full  <= 1'b1;
      r_empty <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/pe_nic.sv
// pe_nic -- processor-to-router network interface with one output and one
// input packet buffer, accessed through a four-register map.
//
// Optional feature: define PE_NIC_IRQ_EN to add output nic_irq (tracks in_full).
//
// Ports:
//   clk          : clock, rising-edge
//   reset        : asynchronous active-low reset
//   nic_addr     : register select (0 out buf, 1 out status, 2 in buf, 3 in status)
//   nic_di       : processor write data
//   nic_en       : access strobe
//   nic_wrEn     : 1 = write, 0 = read
//   nic_do       : registered read data, holds between reads
//   peri         : router ready to accept an injected packet
//   pesi / pedi  : injection strobe and data (one-cycle pulse, zero otherwise)
//   peso / pedo  : ejection strobe and data from the router
//   pero         : NIC ready for ejection (registered, equals ~in_full)
//   nic_irq      : (PE_NIC_IRQ_EN only) input buffer holds a packet
//   net_polarity : current router virtual-channel polarity
//
// Handshakes: injection fires at an edge where out_full & peri & the packet's
// VC bit matches net_polarity; ejection is accepted at an edge where
// peso & pero. Packets pass through unmodified in both directions.
module pe_nic
  import pe_nic_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        nic_addr,
  input  logic [DATA_W-1:0] nic_di,
  input  logic              nic_en,
  input  logic              nic_wrEn,
  output logic [DATA_W-1:0] nic_do,
  input  logic              peri,
  output logic              pesi,
  output logic [DATA_W-1:0] pedi,
  input  logic              peso,
  input  logic [DATA_W-1:0] pedo,
  output logic              pero,
`ifdef PE_NIC_IRQ_EN
  output logic              nic_irq,
`endif
  input  logic              net_polarity
);

  logic              w_cpu_wr;
  logic              w_cpu_rd;
  logic              w_out_load;
  logic [DATA_W-1:0] w_out_data;
  logic              w_out_full;
  logic              w_out_empty;
  logic              w_inject;
  logic              w_in_load;
  logic              w_in_clear;
  logic [DATA_W-1:0] w_in_data;
  logic              w_in_full;
  logic              w_in_empty;

  logic              r_pesi;
  logic [DATA_W-1:0] r_pedi;
  logic [DATA_W-1:0] r_nic_do;

  assign w_cpu_wr = nic_en &  nic_wrEn;
  assign w_cpu_rd = nic_en & ~nic_wrEn;

  // Writes only land in an empty output buffer; this also drops a write that
  // coincides with the injection edge, spacing packets by at least 2 cycles.
  assign w_out_load = w_cpu_wr & (nic_addr == ADDR_OUT_BUF) & w_out_empty;

  assign w_inject = w_out_full & peri & (w_out_data[PKT_VC_BIT] == net_polarity);

  // pero is a flop output, so accepting peso has no combinational path to it.
  assign w_in_load  = peso & pero;
  assign w_in_clear = w_cpu_rd & (nic_addr == ADDR_IN_BUF);

  nic_chan_buf #(.DATA_W(DATA_W)) u_out_buf (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_out_load),
    .i_data  (nic_di),
    .i_clear (w_inject),
    .o_data  (w_out_data),
    .o_full  (w_out_full),
    .o_empty (w_out_empty)
  );

  nic_chan_buf #(.DATA_W(DATA_W)) u_in_buf (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_in_load),
    .i_data  (pedo),
    .i_clear (w_in_clear),
    .o_data  (w_in_data),
    .o_full  (w_in_full),
    .o_empty (w_in_empty)
  );

  // Injection output: one-cycle pulse after the injection edge, zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pesi <= 1'b0;
      r_pedi <= '0;
    end else if (w_inject) begin
      r_pesi <= 1'b1;
      r_pedi <= w_out_data;
    end else begin
      r_pesi <= 1'b0;
      r_pedi <= '0;
    end
  end

  // Read data register; holds its value when no read is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nic_do <= '0;
    end else if (w_cpu_rd) begin
      case (nic_addr)
        ADDR_OUT_STAT: r_nic_do <= {{(DATA_W-1){1'b0}}, w_out_full};
        ADDR_IN_BUF:   r_nic_do <= w_in_data;
        ADDR_IN_STAT:  r_nic_do <= {{(DATA_W-1){1'b0}}, w_in_full};
        default:       r_nic_do <= '0;
      endcase
    end
  end

  assign pesi   = r_pesi;
  assign pedi   = r_pedi;
  assign nic_do = r_nic_do;
  assign pero   = w_in_empty;

`ifdef PE_NIC_IRQ_EN
  assign nic_irq = w_in_full;
`endif

endmodule

// File: tb/tb_pe_nic.sv
// tb_pe_nic -- directed bench for pe_nic with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. Build with +define+PE_NIC_IRQ_EN to also check nic_irq.
module tb_pe_nic;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic [1:0]   nic_addr;
  logic [W-1:0] nic_di;
  logic         nic_en;
  logic         nic_wrEn;
  logic [W-1:0] nic_do;
  logic         peri;
  logic         pesi;
  logic [W-1:0] pedi;
  logic         peso;
  logic [W-1:0] pedo;
  logic         pero;
  logic         net_polarity;
`ifdef PE_NIC_IRQ_EN
  logic         nic_irq;
`endif

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pe_nic #(.DATA_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .nic_addr     (nic_addr),
    .nic_di       (nic_di),
    .nic_en       (nic_en),
    .nic_wrEn     (nic_wrEn),
    .nic_do       (nic_do),
    .peri         (peri),
    .pesi         (pesi),
    .pedi         (pedi),
    .peso         (peso),
    .pedo         (pedo),
    .pero         (pero),
`ifdef PE_NIC_IRQ_EN
    .nic_irq      (nic_irq),
`endif
    .net_polarity (net_polarity)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    nic_addr = a; nic_di = d; nic_en = 1'b1; nic_wrEn = 1'b1;
    tick();
    nic_en = 1'b0; nic_wrEn = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [W-1:0] d);
    @(negedge clk);
    nic_addr = a; nic_en = 1'b1; nic_wrEn = 1'b0;
    tick();
    d = nic_do;
    nic_en = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] rd;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0; nic_addr = 2'd0; nic_di = '0; nic_en = 1'b0; nic_wrEn = 1'b0;
    peri = 1'b0; peso = 1'b0; pedo = '0; net_polarity = 1'b1;

    // Reset state
    repeat (2) tick();
    check("rst_pesi", {63'd0, pesi}, 64'd0);
    check("rst_pedi", pedi, 64'd0);
    check("rst_nic_do", nic_do, 64'd0);
    check("rst_pero", {63'd0, pero}, 64'd1);
`ifdef PE_NIC_IRQ_EN
    check("rst_irq", {63'd0, nic_irq}, 64'd0);
`endif
    @(negedge clk); reset = 1'b1;

    // Injection waits for matching polarity
    peri = 1'b1;
    cpu_write(2'd0, 64'h401200000000FFFF);
    check("inj_wait_pol", {63'd0, pesi}, 64'd0);
    cpu_read(2'd1, rd);
    check("out_stat_full", rd, 64'd1);
    check("inj_still_wait", {63'd0, pesi}, 64'd0);
    @(negedge clk); net_polarity = 1'b0;
    tick();
    check("inj_pesi", {63'd0, pesi}, 64'd1);
    check("inj_pedi", pedi, 64'h401200000000FFFF);
    tick();
    check("inj_pesi_end", {63'd0, pesi}, 64'd0);
    check("inj_pedi_end", pedi, 64'd0);
    cpu_read(2'd1, rd);
    check("out_stat_empty", rd, 64'd0);

    // Write while full is dropped
    @(negedge clk); peri = 1'b0;
    cpu_write(2'd0, 64'h0010000000ABCDEF);
    cpu_write(2'd0, 64'h0010000012345678);
    cpu_read(2'd1, rd);
    check("drop_stat", rd, 64'd1);
    check("drop_no_inj", {63'd0, pesi}, 64'd0);
    @(negedge clk); peri = 1'b1;
    tick();
    check("drop_pesi", {63'd0, pesi}, 64'd1);
    check("drop_pedi_first", pedi, 64'h0010000000ABCDEF);
    tick();
    check("drop_pesi_end", {63'd0, pesi}, 64'd0);
    cpu_read(2'd1, rd);
    check("drop_stat_end", rd, 64'd0);

    // Write at the injection edge is dropped
    cpu_write(2'd0, 64'h00000000000000C1);
    check("b2b_no_inj_yet", {63'd0, pesi}, 64'd0);
    cpu_write(2'd0, 64'h00000000000000D2);
    check("b2b_pesi", {63'd0, pesi}, 64'd1);
    check("b2b_pedi", pedi, 64'h00000000000000C1);
    tick();
    check("b2b_pesi_end", {63'd0, pesi}, 64'd0);
    cpu_read(2'd1, rd);
    check("b2b_stat", rd, 64'd0);

    // VC bit = 1 waits for polarity 1, header passes through
    cpu_write(2'd0, 64'h8000000000000001);
    tick();
    check("vc1_wait", {63'd0, pesi}, 64'd0);
    @(negedge clk); net_polarity = 1'b1;
    tick();
    check("vc1_pesi", {63'd0, pesi}, 64'd1);
    check("vc1_pedi", pedi, 64'h8000000000000001);
    tick();
    check("vc1_pesi_end", {63'd0, pesi}, 64'd0);

    // Ejection
    @(negedge clk); peso = 1'b1; pedo = 64'h00000000000DDA42;
    tick();
    check("ej_pero_low", {63'd0, pero}, 64'd0);
`ifdef PE_NIC_IRQ_EN
    check("ej_irq", {63'd0, nic_irq}, 64'd1);
`endif
    @(negedge clk); pedo = 64'h0002000000053FDA;
    tick();
    @(negedge clk); peso = 1'b0;
    cpu_read(2'd3, rd);
    check("ej_in_stat", rd, 64'd1);
    cpu_read(2'd2, rd);
    check("ej_in_data", rd, 64'h00000000000DDA42);
    check("ej_pero_high", {63'd0, pero}, 64'd1);
    cpu_read(2'd2, rd);
    check("ej_stale", rd, 64'h00000000000DDA42);
    check("ej_stale_pero", {63'd0, pero}, 64'd1);
    cpu_read(2'd3, rd);
    check("ej_in_stat_clr", rd, 64'd0);

    // Simultaneous addr2 read and peso while full: peso dropped
    @(negedge clk); peso = 1'b1; pedo = 64'h0000000000001111;
    tick();
    check("sim_pero_low", {63'd0, pero}, 64'd0);
    @(negedge clk);
    nic_addr = 2'd2; nic_en = 1'b1; nic_wrEn = 1'b0; pedo = 64'h0000000000002222;
    tick();
    check("sim_rd", nic_do, 64'h0000000000001111);
    check("sim_pero_high", {63'd0, pero}, 64'd1);
    @(negedge clk); nic_en = 1'b0; peso = 1'b0;
    cpu_read(2'd3, rd);
    check("sim_in_stat", rd, 64'd0);
    cpu_read(2'd2, rd);
    check("sim_in_data", rd, 64'h0000000000001111);

    // addr0 reads 0; writes to status registers ignored
    cpu_read(2'd0, rd);
    check("rd_addr0", rd, 64'd0);
    cpu_write(2'd1, 64'hFFFFFFFFFFFFFFFF);
    cpu_write(2'd3, 64'hFFFFFFFFFFFFFFFF);
    cpu_read(2'd1, rd);
    check("wr_stat_ign_out", rd, 64'd0);
    cpu_read(2'd3, rd);
    check("wr_stat_ign_in", rd, 64'd0);
    check("wr_stat_no_inj", {63'd0, pesi}, 64'd0);

    // Reset with both buffers full
    @(negedge clk); peri = 1'b0;
    cpu_write(2'd0, 64'h401200000000FFFF);
    @(negedge clk); peso = 1'b1; pedo = 64'h00000000000DDA42;
    tick();
    @(negedge clk); peso = 1'b0;
    check("pre_rst_pero", {63'd0, pero}, 64'd0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_pesi", {63'd0, pesi}, 64'd0);
    check("mid_rst_pero", {63'd0, pero}, 64'd1);
    check("mid_rst_nic_do", nic_do, 64'd0);
`ifdef PE_NIC_IRQ_EN
    check("mid_rst_irq", {63'd0, nic_irq}, 64'd0);
`endif
    @(negedge clk); reset = 1'b1;
    cpu_read(2'd1, rd);
    check("post_rst_out_stat", rd, 64'd0);
    cpu_read(2'd3, rd);
    check("post_rst_in_stat", rd, 64'd0);
    cpu_read(2'd2, rd);
    check("post_rst_in_buf", rd, 64'd0);

    // Reset during the injection pulse
    @(negedge clk); peri = 1'b1; net_polarity = 1'b0;
    cpu_write(2'd0, 64'h0000000000ABCDEF);
    tick();
    check("rinj_pesi", {63'd0, pesi}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rinj_pesi_drop", {63'd0, pesi}, 64'd0);
    check("rinj_pedi_drop", pedi, 64'd0);
    @(negedge clk); reset = 1'b1;
    tick();
    check("rinj_after", {63'd0, pesi}, 64'd0);
    cpu_read(2'd1, rd);
    check("rinj_out_stat", rd, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_nic.md
PE_NIC -- requirements
Module: pe_nic

Interface
REQ-001 SHALL have parameter DATA_W, default 64, packet and processor data width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports nic_addr (input, 2, register select), nic_di (input, DATA_W, processor write data), nic_en (input, 1, access strobe), nic_wrEn (input, 1, 1=write 0=read) and nic_do (output, DATA_W, registered read data).
REQ-005 SHALL have router-injection ports peri (input, 1, router ready), pesi (output, 1, send strobe) and pedi (output, DATA_W, send data).
REQ-006 SHALL have router-ejection ports peso (input, 1, router send strobe), pedo (input, DATA_W, router data) and pero (output, 1, NIC ready).
REQ-007 SHALL have port net_polarity  input  1  current router virtual-channel polarity.

Function
REQ-008 Register map: addr0 = output-channel buffer (write-only), addr1 = output status, addr2 = input-channel buffer (read-only), addr3 = input status.
REQ-009 Processor write to addr0 with nic_en=1, nic_wrEn=1 and output buffer empty before the edge SHALL load nic_di and set out_full.
REQ-010 Write to addr0 while out_full=1 SHALL be dropped, buffer unchanged; writes to addr1-3 SHALL be ignored.
REQ-011 Read (nic_en=1, nic_wrEn=0) SHALL update nic_do at the edge: addr1 -> {0...,out_full}, addr3 -> {0...,in_full}, addr2 -> input buffer contents, addr0 -> 0; nic_do SHALL hold between reads.
REQ-012 Read of addr2 while in_full=1 SHALL clear in_full at the same edge; read of addr2 while empty SHALL return the stale buffer and change no state.
REQ-013 Injection: at an edge with out_full=1, peri=1 and buffer bit 63 == net_polarity, next cycle pesi=1 and pedi=buffer for exactly one cycle, and out_full SHALL clear at that edge.
REQ-014 pesi SHALL be 0 and pedi SHALL be 0 in every cycle not covered by REQ-013.
REQ-015 A processor write to addr0 at the injection edge SHALL be dropped (buffer not empty before the edge); back-to-back packets SHALL therefore be spaced at least 2 cycles.
REQ-016 pero SHALL equal ~in_full, driven from a register with no combinational path from peso.
REQ-017 Ejection: at an edge with peso=1 and pero=1, pedo SHALL be captured into the input buffer and in_full set; peso while pero=0 SHALL be ignored.
REQ-018 A simultaneous addr2 read and peso at an edge with in_full=1 SHALL clear in_full and drop the peso packet.
REQ-019 No arithmetic; header bits SHALL pass through unmodified in both directions.

Reset
REQ-020 While reset=0: out_full=0, in_full=0, pesi=0, pedi=0, nic_do=0, pero=1, both buffers zero.
REQ-021 Reset asserted mid-injection SHALL drop the pending packet and deassert pesi immediately.

Configuration
REQ-022 With PE_NIC_IRQ_EN defined, an extra output nic_irq (1 bit) SHALL exist, registered, equal to in_full, reset 0.
REQ-023 Without PE_NIC_IRQ_EN, nic_irq SHALL not exist and the behaviour SHALL otherwise be identical.

Structure
REQ-024 Package pe_nic_pkg SHALL hold the register-address constants (ADDR_OUT_BUF, ADDR_OUT_STAT, ADDR_IN_BUF, ADDR_IN_STAT) and the polarity bit index (PKT_VC_BIT = 63).
REQ-025 A one-entry buffer-with-full-flag sub-module nic_chan_buf SHALL be instantiated twice, once per direction.

Verification
REQ-026 Write addr0 64'h401200000000FFFF, net_polarity=0 toggling, peri=1 -> pesi pulses one cycle after the first edge where polarity=0, pedi=64'h401200000000FFFF, then addr1 read = 0.
REQ-027 Write addr0 64'h0010000000ABCDEF, then write addr0 64'h0010000012345678 with peri=0 -> second write dropped; after peri=1 only the first value is injected.
REQ-028 peso=1 with pedo=64'h00000000000DDA42 -> pero=0 next cycle, addr3 read = 1, addr2 read = 64'h00000000000DDA42, then pero=1.
REQ-029 Second peso with 64'h0002000000053FDA while in_full=1 -> ignored; addr2 still returns 64'h00000000000DDA42.
REQ-030 Assert reset with out_full=1 and in_full=1 -> pesi=0, pero=1, addr1 and addr3 read 0 after release; with PE_NIC_IRQ_EN, nic_irq=0.
